// File: rtl/draw_scheduler_pkg.sv
// Shared types and default cycle budgets for the draw scheduler.
// ctrl_for() gives the steady-state control word of each state.
package draw_scheduler_pkg;

  localparam int unsigned DEF_FRAME_DIV    = 833333;
  localparam int unsigned DEF_CLEAR_CYCLES = 19201;
  localparam int unsigned DEF_DRAW_CYCLES  = 6000;

  typedef enum logic [3:0] {
    CLR_LD   = 4'd0,
    CLR      = 4'd1,
    IDLE     = 4'd2,
    WAIT     = 4'd3,
    ERASE_LD = 4'd4,
    ERASE    = 4'd5,
    UPDATE   = 4'd6,
    DRAW_LD  = 4'd7,
    DRAW     = 4'd8,
    OVER     = 4'd9
  } state_e;

  typedef struct packed {
    logic ld_rs;
    logic ld_sw;
    logic ld_erase;
    logic enable;
    logic plot;
    logic update_game;
    logic restart_game;
    logic dropped_frame;
  } ctrl_t;

  function automatic ctrl_t ctrl_for(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      CLR_LD:   c.ld_rs = 1'b1;
      CLR:      begin c.enable = 1'b1; c.plot = 1'b1; end
      ERASE_LD: begin c.ld_sw = 1'b1; c.ld_erase = 1'b1; end
      ERASE:    begin c.enable = 1'b1; c.plot = 1'b1; c.ld_erase = 1'b1; end
      UPDATE:   c.update_game = 1'b1;
      DRAW_LD:  c.ld_sw = 1'b1;
      DRAW:     begin c.enable = 1'b1; c.plot = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// Control bundle between the scheduler (master) and the datapath/game logic (slave).
interface draw_scheduler_if;
  logic start;
  logic game_over;
  logic ld_rs;
  logic ld_sw;
  logic ld_erase;
  logic enable;
  logic plot;
  logic update_game;
  logic restart_game;
  logic dropped_frame;

  modport master (
    input  start, game_over,
    output ld_rs, ld_sw, ld_erase, enable, plot,
           update_game, restart_game, dropped_frame
  );

  modport slave (
    output start, game_over,
    input  ld_rs, ld_sw, ld_erase, enable, plot,
           update_game, restart_game, dropped_frame
  );
endinterface

// File: rtl/draw_scheduler_frame_timer.sv
// Free-running frame timer: counts 0..FRAME_DIV-1 and emits a registered
// one-cycle tick in the cycle after the wrap.
module frame_timer #(
  parameter int unsigned FRAME_DIV = 833333
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // next count and wrap detection
  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tick_d = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      tick_d = 1'b0;
    end
  end

  // counter and tick registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/draw_scheduler.sv
// Frame sequencer for the pixel datapath: clear, idle, per-frame erase/update/draw,
// game-over hold. All controls are registered from the next state.
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int unsigned FRAME_DIV    = DEF_FRAME_DIV,
  parameter int unsigned CLEAR_CYCLES = DEF_CLEAR_CYCLES,
  parameter int unsigned DRAW_CYCLES  = DEF_DRAW_CYCLES
) (
  input  logic              clk,
  input  logic              reset_n,
  draw_scheduler_if.master  bus
);

  localparam int unsigned CNT_MAX = (CLEAR_CYCLES > DRAW_CYCLES) ? CLEAR_CYCLES : DRAW_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] DRAW_LAST = CW'(DRAW_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          game_active_q, game_active_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic          tick_s;
  logic          active_s;
  logic          restart_s;
  logic          dropped_s;

  frame_timer #(.FRAME_DIV(FRAME_DIV)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick_s)
  );

  // next state, pass counter, overrun tracking and control word
  always_comb begin
    state_d       = state_q;
    game_active_d = game_active_q;
    restart_s     = 1'b0;
    case (state_q)
      // CLR_LD holds until ld_rs has actually been driven for one cycle
      CLR_LD:   if (ctrl_q.ld_rs) state_d = CLR; else state_d = CLR_LD;
      CLR:      if (cnt_q == CLR_LAST) state_d = game_active_q ? WAIT : IDLE;
                else state_d = CLR;
      IDLE, OVER: begin
        if (bus.start) begin
          state_d       = CLR_LD;
          restart_s     = 1'b1;
          game_active_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      WAIT: begin
        if (bus.game_over)             state_d = OVER;
        else if (tick_s || pending_q)  state_d = ERASE_LD;
        else                           state_d = WAIT;
      end
      ERASE_LD: state_d = ERASE;
      ERASE:    if (cnt_q == DRAW_LAST) state_d = UPDATE; else state_d = ERASE;
      UPDATE:   state_d = DRAW_LD;
      DRAW_LD:  state_d = DRAW;
      DRAW:     if (cnt_q == DRAW_LAST) state_d = WAIT; else state_d = DRAW;
      default:  state_d = CLR_LD;
    endcase

    if (state_d != state_q) cnt_d = '0;
    else if (state_q inside {CLR, ERASE, DRAW}) cnt_d = cnt_q + CW'(1);
    else cnt_d = cnt_q;

    // overrun bookkeeping only matters while a clear or pass is running
    active_s  = !(state_q inside {IDLE, OVER, WAIT});
    dropped_s = active_s && tick_s && pending_q;
    if (!active_s || state_d == IDLE) pending_d = 1'b0;
    else if (tick_s)                  pending_d = 1'b1;
    else                              pending_d = pending_q;

    ctrl_d = ctrl_for(state_d);
    if (state_d == CLR_LD) ctrl_d.ld_rs = (state_q == CLR_LD) && !ctrl_q.ld_rs;
    else                   ctrl_d.ld_rs = 1'b0;
    ctrl_d.restart_game  = restart_s;
    ctrl_d.dropped_frame = dropped_s;
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= CLR_LD;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      game_active_q <= 1'b0;
      ctrl_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      game_active_q <= game_active_d;
      ctrl_q        <= ctrl_d;
    end
  end

  assign bus.ld_rs         = ctrl_q.ld_rs;
  assign bus.ld_sw         = ctrl_q.ld_sw;
  assign bus.ld_erase      = ctrl_q.ld_erase;
  assign bus.enable        = ctrl_q.enable;
  assign bus.plot          = ctrl_q.plot;
  assign bus.update_game   = ctrl_q.update_game;
  assign bus.restart_game  = ctrl_q.restart_game;
  assign bus.dropped_frame = ctrl_q.dropped_frame;

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Top-level sequencer for the game's pixel datapath. Generates its load, erase, background-reset and enable controls, and paces each frame from a free-running frame timer.
- Per frame: erase old sprites, pulse the game-logic update, redraw sprites.
- Also owns power-up clear, idle/start, and game-over hold.
- Sits between the game-logic/physics blocks and the datapath; its plot output drives the VGA adapter write enable.

Parameters:
- FRAME_DIV, 833333: clocks per frame tick (50 MHz / 60 Hz).
- CLEAR_CYCLES, 19201: enable cycles for a full-screen background clear (160x120 plus 1 load cycle).
- DRAW_CYCLES, 6000: enable cycles allotted to one erase pass or one draw pass of the pillar/bird/score list.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse from the key synchroniser; begins or restarts a game.
- game_over  in  1  level from collision logic; high = bird has collided.
- ld_rs  out  1  one-cycle pulse; datapath loads the background-clear job.
- ld_sw  out  1  one-cycle pulse; datapath loads the sprite list and latches score digits.
- ld_erase  out  1  level; selects erase colouring for the current sprite pass.
- enable  out  1  datapath step enable.
- plot  out  1  VGA write enable; equals enable.
- update_game  out  1  one-cycle pulse; game logic advances bird, pillars and score.
- restart_game  out  1  one-cycle pulse; game logic reinitialises positions and score.
- dropped_frame  out  1  one-cycle pulse; a frame tick was lost while one was already pending.

Behaviour:
- Reset (async assert):
  - All outputs 0.
  - Counters 0.
  - pending flag 0.
  - State goes to CLR_LD.
- Frame timer:
  - Counts 0..FRAME_DIV-1 continuously in all states.
  - Produces a one-cycle tick at the wrap.
  - Counter width is clog2(FRAME_DIV).
- States and transitions:
  - CLR_LD: ld_rs=1 for 1 cycle -> CLR.
  - CLR: enable=plot=1. Cycle counter runs 0..CLEAR_CYCLES-1, then -> IDLE if no game is active, or -> WAIT if entered via restart.
  - IDLE: all controls 0. On start, pulse restart_game and -> CLR_LD with the restart flag set.
  - WAIT: all controls 0. On tick or pending -> ERASE_LD and clear pending. If game_over=1 on entry, -> OVER instead.
  - ERASE_LD: ld_sw=1, ld_erase=1 for 1 cycle -> ERASE.
  - ERASE: enable=1, ld_erase=1 held for DRAW_CYCLES cycles -> UPDATE.
  - UPDATE: update_game=1, ld_erase=0 for 1 cycle -> DRAW_LD.
  - DRAW_LD: ld_sw=1 for 1 cycle -> DRAW. The datapath samples new positions and scores here, one cycle after update_game.
  - DRAW: enable=1 for DRAW_CYCLES cycles -> WAIT.
  - OVER: picture frozen, no update_game. On start, pulse restart_game and -> CLR_LD (restart).
- Control stability:
  - ld_erase stays constant from ERASE_LD through the last ERASE cycle; it never toggles mid-pass.
  - ld_sw, ld_rs and enable are never high in the same cycle.
- Frame overrun:
  - A tick arriving outside WAIT sets pending.
  - A tick arriving while pending is already set pulses dropped_frame; pending stays 1.
- Simultaneous events:
  - game_over and tick in WAIT: game_over wins -> OVER; pending is cleared.
  - start in any state other than IDLE/OVER is ignored.
  - game_over is sampled only in WAIT, so an in-progress erase/draw pass always completes.
- Cycle counter width is clog2(max(CLEAR_CYCLES, DRAW_CYCLES)); it is reset to 0 on every state entry.
- Reset asserted mid-pass: outputs drop in the same cycle, no further plot. After release the scheduler re-clears the screen (CLR_LD) and lands in IDLE.

Decomposition:
- draw_scheduler_pkg holds the state enum (CLR_LD, CLR, IDLE, WAIT, ERASE_LD, ERASE, UPDATE, DRAW_LD, DRAW, OVER) and default cycle-budget constants.
- One sub-module, frame_timer (parameter FRAME_DIV; ports clk, reset_n, tick), is natural and reusable by the physics block.

Test Plan (FRAME_DIV=20, CLEAR_CYCLES=10, DRAW_CYCLES=4):
- Release reset -> ld_rs high exactly 1 cycle, then enable/plot high exactly 10 cycles, then IDLE with all outputs 0.
- start pulse in IDLE -> restart_game 1 cycle, then ld_rs, 10 clear cycles, then WAIT. At the next tick: ld_sw+ld_erase (1), enable+ld_erase (4), update_game (1), ld_sw with ld_erase=0 (1), enable (4), back to WAIT.
- Force a tick during DRAW -> pending set; the next erase pass starts the cycle after DRAW ends with no wait for a new tick. A second tick before then -> dropped_frame pulses once.
- game_over=1 coinciding with a tick in WAIT -> OVER; no ld_sw and no update_game for 100 cycles. Then start -> restart_game, clear sequence, play resumes.
- Assert reset_n low mid-ERASE -> all outputs 0 in the same cycle (async). After release, the CLR_LD/CLR sequence repeats and the scheduler reaches IDLE.
- start pulsed during DRAW -> ignored: no restart_game, and the sequence timing is unchanged.
